// File: rtl/uarch_pkg.sv
// Shared microarchitecture types for the commit-stream monitor:
// commit port count, architectural field widths and the monitor state encoding.
package uarch_pkg;

  localparam int PIPE_WIDTH = 2;
  localparam int RD_W       = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    MON_IDLE    = 3'd0,
    MON_RUN     = 3'd1,
    MON_DONE    = 3'd2,
    MON_HUNG    = 3'd3,
    MON_TIMEOUT = 3'd4
  } mon_state_e;

endpackage

// File: rtl/commit_popcnt.sv
// Combinational count of asserted commit-valid bits; the single count feeds
// the instret, window and histogram paths of the monitor.
module commit_popcnt #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]             i_we,
  output logic [$clog2(WIDTH+1)-1:0]   o_count
);

  localparam int OW = $clog2(WIDTH + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + OW'(i_we[i]);
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// Commit-stream monitor: run/instret counters, windowed IPC, completion/hang/timeout
// detection. Define COMMIT_MONITOR_HIST_EN to build the per-commit-count cycle histogram.
//
// state   | meaning
// IDLE    | not armed; commits ignored
// RUN     | counting cycles and commits
// DONE    | marker value written to marker register (sticky)
// HUNG    | HANG_CYCLES consecutive cycles without a commit (sticky)
// TIMEOUT | run reached MAX_CYCLES cycles (sticky)
module commit_monitor
  import uarch_pkg::*;
#(
  parameter int          COMMIT_WIDTH  = PIPE_WIDTH,
  parameter int          CNT_WIDTH     = 48,
  parameter int          WINDOW_CYCLES = 100,
  parameter int          HANG_CYCLES   = 1000,
  parameter int          MAX_CYCLES    = 100000,
  parameter int          DONE_REG      = 31,
  parameter logic [31:0] DONE_VALUE    = 32'hFF
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_start,
  input  logic [COMMIT_WIDTH-1:0]                i_commit_we,
  input  logic [COMMIT_WIDTH*RD_W-1:0]           i_commit_rd,
  input  logic [COMMIT_WIDTH*DATA_W-1:0]         i_commit_data,
  output mon_state_e                             o_state,
  output logic [CNT_WIDTH-1:0]                   o_cycle_count,
  output logic [CNT_WIDTH-1:0]                   o_instret_count,
  output logic [$clog2(WINDOW_CYCLES*COMMIT_WIDTH+1)-1:0] o_window_instret,
  output logic                                   o_window_valid,
  output logic [CNT_WIDTH-1:0]                   o_done_cycle,
  output logic [(COMMIT_WIDTH+1)*CNT_WIDTH-1:0]  o_hist
);

  localparam int PW  = $clog2(COMMIT_WIDTH + 1);
  localparam int WIW = $clog2(WINDOW_CYCLES * COMMIT_WIDTH + 1);
  localparam int WCW = $clog2(WINDOW_CYCLES + 1);
  localparam int HCW = (HANG_CYCLES < 1) ? 1 : $clog2(HANG_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  localparam logic [2:0] S_IDLE    = MON_IDLE;
  localparam logic [2:0] S_RUN     = MON_RUN;
  localparam logic [2:0] S_DONE    = MON_DONE;
  localparam logic [2:0] S_HUNG    = MON_HUNG;
  localparam logic [2:0] S_TIMEOUT = MON_TIMEOUT;

  logic [2:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cycle;
  logic [CNT_WIDTH-1:0] r_instret;
  logic [CNT_WIDTH-1:0] r_done_cycle;
  logic [WIW-1:0]       r_win_instret;
  logic [WIW-1:0]       r_win_acc;
  logic                 r_win_valid;
  logic [WCW-1:0]       r_win_left;
  logic [HCW-1:0]       r_hang_left;

  logic [PW-1:0]        w_pop;
  logic [CNT_WIDTH:0]   w_cycle_sum;
  logic [CNT_WIDTH:0]   w_instret_sum;
  logic [CNT_WIDTH-1:0] w_cycle_nxt;
  logic [CNT_WIDTH-1:0] w_instret_nxt;
  logic [WIW-1:0]       w_win_sum;
  logic                 w_win_last;
  logic                 w_done_hit;
  logic                 w_to_hit;
  logic                 w_hang_hit;

  commit_popcnt #(
    .WIDTH (COMMIT_WIDTH)
  ) u_popcnt (
    .i_we    (i_commit_we),
    .o_count (w_pop)
  );

  // Counters stick at all-ones instead of wrapping.
  assign w_cycle_sum   = {1'b0, r_cycle} + (CNT_WIDTH + 1)'(1);
  assign w_instret_sum = {1'b0, r_instret} + (CNT_WIDTH + 1)'(w_pop);
  assign w_cycle_nxt   = w_cycle_sum[CNT_WIDTH] ? CNT_MAX : w_cycle_sum[CNT_WIDTH-1:0];
  assign w_instret_nxt = w_instret_sum[CNT_WIDTH] ? CNT_MAX : w_instret_sum[CNT_WIDTH-1:0];

  assign w_win_sum  = r_win_acc + WIW'(w_pop);
  assign w_win_last = (r_win_left == WCW'(1));

  always_comb begin
    w_done_hit = 1'b0;
    for (int p = 0; p < COMMIT_WIDTH; p++) begin
      if (i_commit_we[p] &&
          (i_commit_rd[p*RD_W +: RD_W] == RD_W'(DONE_REG)) &&
          (i_commit_data[p*DATA_W +: DATA_W] == DONE_VALUE)) begin
        w_done_hit = 1'b1;
      end
    end
  end

  assign w_to_hit   = (MAX_CYCLES != 0) && (w_cycle_nxt == CNT_WIDTH'(MAX_CYCLES));
  // Stall timer counts down through zero-commit cycles; terminal count is 1 on a stall cycle.
  assign w_hang_hit = (HANG_CYCLES != 0) && (w_pop == '0) && (r_hang_left == HCW'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cycle       <= '0;
      r_instret     <= '0;
      r_done_cycle  <= '0;
      r_win_instret <= '0;
      r_win_acc     <= '0;
      r_win_valid   <= 1'b0;
      r_win_left    <= WCW'(WINDOW_CYCLES);
      r_hang_left   <= HCW'(HANG_CYCLES);
    end else if (i_start) begin
      r_state       <= S_RUN;
      r_cycle       <= '0;
      r_instret     <= '0;
      r_done_cycle  <= '0;
      r_win_instret <= '0;
      r_win_acc     <= '0;
      r_win_valid   <= 1'b0;
      r_win_left    <= WCW'(WINDOW_CYCLES);
      r_hang_left   <= HCW'(HANG_CYCLES);
    end else begin
      r_win_valid <= 1'b0;
      if (r_state == S_RUN) begin
        r_cycle   <= w_cycle_nxt;
        r_instret <= w_instret_nxt;

        if (w_win_last) begin
          r_win_instret <= w_win_sum;
          r_win_valid   <= 1'b1;
          r_win_acc     <= '0;
          r_win_left    <= WCW'(WINDOW_CYCLES);
        end else begin
          r_win_acc  <= w_win_sum;
          r_win_left <= r_win_left - WCW'(1);
        end

        if (w_pop != '0) begin
          r_hang_left <= HCW'(HANG_CYCLES);
        end else if (r_hang_left != '0) begin
          r_hang_left <= r_hang_left - HCW'(1);
        end

        if (w_done_hit) begin
          r_state      <= S_DONE;
          r_done_cycle <= w_cycle_nxt;
        end else if (w_to_hit) begin
          r_state <= S_TIMEOUT;
        end else if (w_hang_hit) begin
          r_state <= S_HUNG;
        end
      end
    end
  end

`ifdef COMMIT_MONITOR_HIST_EN
  logic [CNT_WIDTH-1:0] r_hist [COMMIT_WIDTH+1];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      for (int k = 0; k <= COMMIT_WIDTH; k++) begin
        r_hist[k] <= '0;
      end
    end else if (r_state == S_RUN) begin
      for (int k = 0; k <= COMMIT_WIDTH; k++) begin
        if ((w_pop == PW'(k)) && (r_hist[k] != CNT_MAX)) begin
          r_hist[k] <= r_hist[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    o_hist = '0;
    for (int k = 0; k <= COMMIT_WIDTH; k++) begin
      o_hist[k*CNT_WIDTH +: CNT_WIDTH] = r_hist[k];
    end
  end
`else
  assign o_hist = '0;
`endif

  assign o_state          = mon_state_e'(r_state);
  assign o_cycle_count    = r_cycle;
  assign o_instret_count  = r_instret;
  assign o_window_instret = r_win_instret;
  assign o_window_valid   = r_win_valid;
  assign o_done_cycle     = r_done_cycle;

endmodule

// File: tb/tb_commit_monitor.sv
// Randomized and directed bench for commit_monitor with a queue-based scoreboard
// fed by a cycle-level reference model; honours COMMIT_MONITOR_HIST_EN.
module tb_commit_monitor;
  import uarch_pkg::*;

  localparam int CW   = 2;
  localparam int CNTW = 10;
  localparam int WIN  = 100;
  localparam int HANG = 50;
  localparam int MAXC = 600;
  localparam int DREG = 31;
  localparam logic [31:0] DVAL = 32'hFF;
  localparam int WIW = $clog2(WIN * CW + 1);
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [CW-1:0] we = '0;
  logic [CW*5-1:0] rd = '0;
  logic [CW*32-1:0] dat = '0;
  mon_state_e st;
  logic [CNTW-1:0] cyc, ins, dcyc;
  logic [WIW-1:0] wins;
  logic wval;
  logic [(CW+1)*CNTW-1:0] hist;

  always #5 clk = ~clk;

  commit_monitor #(
    .COMMIT_WIDTH (CW), .CNT_WIDTH (CNTW), .WINDOW_CYCLES (WIN), .HANG_CYCLES (HANG),
    .MAX_CYCLES (MAXC), .DONE_REG (DREG), .DONE_VALUE (DVAL)
  ) dut (
    .i_clk (clk), .i_rst (rst), .i_start (start),
    .i_commit_we (we), .i_commit_rd (rd), .i_commit_data (dat),
    .o_state (st), .o_cycle_count (cyc), .o_instret_count (ins),
    .o_window_instret (wins), .o_window_valid (wval),
    .o_done_cycle (dcyc), .o_hist (hist)
  );

  typedef struct {
    int st; int cyc; int ins; int dcyc; int wi; int wv; longint hist;
  } snap_t;

  snap_t sq[$];
  int    wq[$];
  int    checks = 0;
  int    failures = 0;

  // reference model state
  mon_state_e m_st = MON_IDLE;
  int m_cyc, m_ins, m_dcyc, m_wi, m_wv, m_wcnt, m_wacc, m_stall;
  int m_hist[CW+1];

  int sample_idx = 0, last_pulse = -1, pulse_gap = 0, pulse_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  task automatic model_clear();
    m_cyc = 0; m_ins = 0; m_dcyc = 0; m_wi = 0; m_wv = 0;
    m_wcnt = 0; m_wacc = 0; m_stall = 0;
    for (int k = 0; k <= CW; k++) m_hist[k] = 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic [CW-1:0] w,
                            input logic [CW*5-1:0] rdv, input logic [CW*32-1:0] dv);
    int n;
    bit hit;
    snap_t e;
    longint h;
    if (r) begin
      model_clear(); m_st = MON_IDLE;
    end else if (s) begin
      model_clear(); m_st = MON_RUN;
    end else begin
      m_wv = 0;
      if (m_st == MON_RUN) begin
        n = $countones(w);
        m_cyc = sat(m_cyc + 1);
        m_ins = sat(m_ins + n);
        m_hist[n] = sat(m_hist[n] + 1);
        m_wacc += n;
        m_wcnt++;
        if (m_wcnt == WIN) begin
          m_wi = m_wacc; m_wv = 1; m_wacc = 0; m_wcnt = 0;
          wq.push_back(m_wi);
        end
        m_stall = (n == 0) ? m_stall + 1 : 0;
        hit = 0;
        for (int p = 0; p < CW; p++)
          if (w[p] && rdv[p*5 +: 5] == 5'(DREG) && dv[p*32 +: 32] == DVAL) hit = 1;
        if (hit) begin
          m_st = MON_DONE; m_dcyc = m_cyc;
        end else if (m_cyc == MAXC) m_st = MON_TIMEOUT;
        else if (m_stall >= HANG) m_st = MON_HUNG;
      end
    end
    h = 0;
`ifdef COMMIT_MONITOR_HIST_EN
    for (int k = 0; k <= CW; k++) h |= longint'(m_hist[k]) << (k * CNTW);
`endif
    e.st = int'(m_st); e.cyc = m_cyc; e.ins = m_ins; e.dcyc = m_dcyc;
    e.wi = m_wi; e.wv = m_wv; e.hist = h;
    sq.push_back(e);
  endtask

  task automatic drive(input logic r, input logic s, input logic [CW-1:0] w,
                       input logic [CW*5-1:0] rdv, input logic [CW*32-1:0] dv);
    @(negedge clk);
    rst = r; start = s; we = w; rd = rdv; dat = dv;
    model_step(r, s, w, rdv, dv);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  function automatic logic [CW*5-1:0] rd_safe();
    return {5'($urandom_range(0, 30)), 5'($urandom_range(0, 30))};
  endfunction

  function automatic logic [CW*32-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  // monitor: pops one expected snapshot per clock and checks window pulses
  initial begin
    snap_t e;
    forever begin
      @(posedge clk); #1;
      sample_idx++;
      if (wval === 1'b1) begin
        pulse_cnt++;
        if (last_pulse >= 0) pulse_gap = sample_idx - last_pulse;
        last_pulse = sample_idx;
        chk("window_pulse_expected", 64'(wq.size() > 0), 1);
        if (wq.size() > 0) chk("window_value", 64'(wins), 64'(wq.pop_front()));
      end
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("state", 64'(st), 64'(e.st));
        chk("cycle_count", 64'(cyc), 64'(e.cyc));
        chk("instret_count", 64'(ins), 64'(e.ins));
        chk("done_cycle", 64'(dcyc), 64'(e.dcyc));
        chk("window_instret", 64'(wins), 64'(e.wi));
        chk("window_valid", 64'(wval), 64'(e.wv));
        chk("hist", 64'(hist), 64'(e.hist));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint hsum;
    logic [CW-1:0] w;
    logic [CW*5-1:0] rv;
    logic [CW*32-1:0] dv;
    int len;

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    settle();
    chk("reset_state", 64'(st), 64'(MON_IDLE));
    chk("reset_instret", 64'(ins), 0);

    // completion after 10 full-width cycles
    drive(0, 1, 2'b11, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 2'b11, 0, 0);
    drive(0, 0, 2'b11, {5'd31, 5'd3}, {32'hFF, 32'h12});
    settle();
    chk("done_state", 64'(st), 64'(MON_DONE));
    chk("done_instret", 64'(ins), 22);
    chk("done_cycles", 64'(cyc), 11);
    chk("done_cycle_latch", 64'(dcyc), 11);
    for (int i = 0; i < 3; i++) drive(0, 0, 2'b11, rd_safe(), rnd_data());

    // re-arm from DONE, then two windows of alternating 1/2 commits
    pulse_cnt = 0; last_pulse = -1;
    drive(0, 1, 2'b11, 0, 0);
    settle();
    chk("rearm_state", 64'(st), 64'(MON_RUN));
    chk("rearm_cycles", 64'(cyc), 0);
    chk("rearm_done_cycle", 64'(dcyc), 0);
    for (int i = 0; i < 200; i++) drive(0, 0, (i % 2 == 0) ? 2'b01 : 2'b11, 0, 0);
    settle();
    chk("window_pulses", 64'(pulse_cnt), 2);
    chk("window_gap", 64'(pulse_gap), 100);
    chk("window_ipc", 64'(wins), 150);

    // hang: commits stop after cycle 20
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 60; i++) drive(0, 0, 2'b00, 0, 0);
    settle();
    chk("hang_state", 64'(st), 64'(MON_HUNG));
    chk("hang_cycles", 64'(cyc), 70);
    chk("hang_instret", 64'(ins), 20);

    // reset mid-run wins over start
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 0, 2'b11, 0, 0);
    drive(1, 1, 2'b11, 0, 0);
    settle();
    chk("rst_state", 64'(st), 64'(MON_IDLE));
    chk("rst_cycles", 64'(cyc), 0);
    chk("rst_instret", 64'(ins), 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 2'b11, rd_safe(), rnd_data());

    // completion on the timeout cycle beats timeout
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < MAXC - 1; i++) drive(0, 0, 2'($urandom_range(1, 3)), 0, 0);
    drive(0, 0, 2'b01, {5'd0, 5'd31}, {32'h0, 32'hFF});
    settle();
    chk("to_done_state", 64'(st), 64'(MON_DONE));
    chk("to_done_cycle", 64'(dcyc), MAXC);

    // completion one cycle late: timeout wins
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < MAXC; i++) drive(0, 0, 2'($urandom_range(1, 3)), 0, 0);
    drive(0, 0, 2'b01, {5'd0, 5'd31}, {32'h0, 32'hFF});
    settle();
    chk("timeout_state", 64'(st), 64'(MON_TIMEOUT));
    chk("timeout_cycles", 64'(cyc), MAXC);

    // instret saturation
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 530; i++) drive(0, 0, 2'b11, 0, 0);
    settle();
    chk("sat_instret", 64'(ins), CNT_MAX);
    chk("sat_cycles", 64'(cyc), 530);
    drive(0, 0, 2'b10, {5'd31, 5'd0}, {32'hFF, 32'h0});

    // marker value to x0 is not completion
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hFF});
    settle();
    chk("rd0_no_done", 64'(st), 64'(MON_RUN));
    chk("rd0_counts", 64'(ins), 1);

    // random commits for the histogram
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      dv = rnd_data();
      if ($urandom_range(0, 1) == 1) dv[31:0] = 32'hFF;
      drive(0, 0, 2'($urandom_range(0, 3)), rd_safe(), dv);
    end
    settle();
    chk("hist_run_cycles", 64'(cyc), 500);
    hsum = 0;
    for (int k = 0; k <= CW; k++) hsum += longint'(hist[k*CNTW +: CNTW]);
`ifdef COMMIT_MONITOR_HIST_EN
    chk("hist_sum", 64'(hsum), 500);
`else
    chk("hist_disabled", 64'(hsum), 0);
`endif

    // random episodes, occasional marker, start or reset
    for (int ep = 0; ep < 8; ep++) begin
      drive(0, 1, 0, 0, 0);
      len = $urandom_range(20, 150);
      for (int i = 0; i < len; i++) begin
        w = 2'($urandom_range(0, 3));
        rv = ($urandom_range(0, 3) == 0) ? {5'd31, 5'd31} : 10'($urandom);
        dv = ($urandom_range(0, 15) == 0) ? {32'hFF, 32'hFF} : rnd_data();
        drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 199) == 0), w, rv, dv);
      end
    end
    drive(0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sq.size()), 0);
    chk("window_queue_drained", 64'(wq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
